// File: rtl/stg0ia_pkg.sv
// Shared widths, FSM encodings and the fetched-word record for the
// instruction-address stage.
package stg0ia_pkg;
  localparam int SIZE_ADDR = 16;
  localparam int SIZE_DATA = 32;

  // Reusable by hazard/debug logic that needs to observe the fetch FSM.
  typedef enum logic [1:0] {
    S_RESET = 2'd0,
    S_FETCH = 2'd1,
    S_STALL = 2'd2
  } ia_state_e;

  typedef struct packed {
    logic [SIZE_ADDR-1:0] pc;
    logic [SIZE_DATA-1:0] data;
  } ia_word_t;
endpackage

// File: rtl/stg0ia_if.sv
// Fetch-side bundle: control from downstream, the instruction-memory
// handshake and the word delivered to stg1if.
interface stg0ia_if;
  import stg0ia_pkg::*;

  logic                 iw_stall;
  logic                 iw_redirect;
  logic [SIZE_ADDR-1:0] iw_redirect_pc;
  logic                 iw_mem_gnt;
  logic [SIZE_DATA-1:0] iw_mem_data;
  logic                 ow_mem_req;
  logic [SIZE_ADDR-1:0] ow_mem_addr;
  logic                 ow_ia_valid;
  logic [SIZE_ADDR-1:0] ow_pc;
  logic [SIZE_DATA-1:0] ow_mem_data;

  modport master (
    input  iw_stall, iw_redirect, iw_redirect_pc, iw_mem_gnt, iw_mem_data,
    output ow_mem_req, ow_mem_addr, ow_ia_valid, ow_pc, ow_mem_data
  );

  modport slave (
    output iw_stall, iw_redirect, iw_redirect_pc, iw_mem_gnt, iw_mem_data,
    input  ow_mem_req, ow_mem_addr, ow_ia_valid, ow_pc, ow_mem_data
  );
endinterface

// File: rtl/stg0ia_skid.sv
// One-entry {pc,data} holding register for a word that returns from memory
// while the downstream stage is stalled.
module ia_skid
  import stg0ia_pkg::*;
(
  input  logic     i_clk,
  input  logic     i_rst,
  input  logic     i_load,
  input  logic     i_clear,
  input  ia_word_t i_d,
  output logic     o_valid,
  output ia_word_t o_q
);
  logic     r_valid;
  ia_word_t r_q;

  // Clear wins: a redirect landing with a returning word must drop it.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid <= 1'b0;
      r_q     <= '0;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_q     <= i_d;
    end
  end

  assign o_valid = r_valid;
  assign o_q     = r_q;
endmodule

// File: rtl/stg0ia.sv
// Instruction-address stage: owns the fetch PC, issues pipelined reads to
// instruction memory and hands each returned word with its PC to stg1if.
module stg0ia
  import stg0ia_pkg::*;
#(
  parameter logic [SIZE_ADDR-1:0] RESET_PC  = '0,
  parameter int unsigned          ADDR_STEP = 1
) (
  input  logic iw_clk,
  input  logic iw_rst,
  stg0ia_if.master bus
);
  localparam logic [SIZE_ADDR-1:0] LP_STEP = SIZE_ADDR'(ADDR_STEP);

  ia_state_e            r_state;
  logic [SIZE_ADDR-1:0] r_pc;
  logic                 r_inflight;
  logic [SIZE_ADDR-1:0] r_inflight_pc;

  logic     w_req;
  logic     w_accept;
  logic     w_deliver;
  logic     w_skid_load;
  logic     w_skid_clear;
  logic     w_skid_valid;
  ia_word_t w_skid_d;
  ia_word_t w_skid_q;

  assign w_req    = (r_state == S_FETCH) & ~bus.iw_stall & ~bus.iw_redirect;
  assign w_accept = w_req & bus.iw_mem_gnt;

  assign w_deliver = ~bus.iw_stall & ~bus.iw_redirect & (w_skid_valid | r_inflight);

  // No grant can occur during a stall, so the skid never needs a second entry.
  assign w_skid_load  = r_inflight & bus.iw_stall & ~bus.iw_redirect;
  assign w_skid_clear = bus.iw_redirect | (w_deliver & w_skid_valid);
  assign w_skid_d     = '{pc: r_inflight_pc, data: bus.iw_mem_data};

  ia_skid u_skid (
    .i_clk   (iw_clk),
    .i_rst   (iw_rst),
    .i_load  (w_skid_load),
    .i_clear (w_skid_clear),
    .i_d     (w_skid_d),
    .o_valid (w_skid_valid),
    .o_q     (w_skid_q)
  );

  always_ff @(posedge iw_clk) begin
    if (iw_rst) begin
      r_state       <= S_RESET;
      r_pc          <= RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
    end else begin
      case (r_state)
        S_RESET: r_state <= S_FETCH;
        S_FETCH: if (bus.iw_stall)  r_state <= S_STALL;
        S_STALL: if (!bus.iw_stall) r_state <= S_FETCH;
        default: r_state <= S_RESET;
      endcase

      if (bus.iw_redirect) begin
        r_pc       <= bus.iw_redirect_pc;
        r_inflight <= 1'b0;
      end else if (w_accept) begin
        r_pc          <= r_pc + LP_STEP;
        r_inflight    <= 1'b1;
        r_inflight_pc <= r_pc;
      end else begin
        r_inflight <= 1'b0;
      end
    end
  end

  assign bus.ow_mem_req  = w_req;
  assign bus.ow_mem_addr = r_pc;
  assign bus.ow_ia_valid = w_deliver;

  // A held word is always older than anything in flight, so it goes first.
  always_comb begin
    bus.ow_pc       = '0;
    bus.ow_mem_data = '0;
    if (w_deliver) begin
      if (w_skid_valid) begin
        bus.ow_pc       = w_skid_q.pc;
        bus.ow_mem_data = w_skid_q.data;
      end else begin
        bus.ow_pc       = r_inflight_pc;
        bus.ow_mem_data = bus.iw_mem_data;
      end
    end
  end
endmodule

// File: tb/tb_stg0ia.sv
// Directed bench for stg0ia: walks reset, grant back-pressure, stall/skid,
// redirect, PC wrap and mid-stream reset, one cycle at a time.
module tb_stg0ia;
  import stg0ia_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  stg0ia_if bus ();

  stg0ia #(.RESET_PC(16'h0100), .ADDR_STEP(1)) dut (
    .iw_clk (clk),
    .iw_rst (rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [15:0] a);
    return (a == 16'h0105) ? 32'h0000DEAD : {16'hC0DE, a};
  endfunction

  // Instruction memory: read data appears the cycle after an accepted request.
  always @(posedge clk)
    bus.iw_mem_data <= (bus.ow_mem_req && bus.iw_mem_gnt) ? memf(bus.ow_mem_addr) : 32'hBAD0BAD0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic cyc(input string tag, input logic req, input logic [15:0] addr,
                     input logic vld, input logic [15:0] pc, input logic [31:0] data);
    #1;
    chk({tag, ".req"},   32'(bus.ow_mem_req),  32'(req));
    chk({tag, ".addr"},  32'(bus.ow_mem_addr), 32'(addr));
    chk({tag, ".valid"}, 32'(bus.ow_ia_valid), 32'(vld));
    chk({tag, ".pc"},    32'(bus.ow_pc),       32'(pc));
    chk({tag, ".data"},  bus.ow_mem_data,      data);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.iw_stall       = 1'b0;
    bus.iw_redirect    = 1'b0;
    bus.iw_redirect_pc = '0;
    bus.iw_mem_gnt     = 1'b1;
    tick(); tick();
    cyc("reset", 0, 16'h0100, 0, 16'h0, 32'h0);

    // 1: reset release and back-to-back fetch
    rst = 1'b0;
    cyc("t1_bubble", 0, 16'h0100, 0, 16'h0, 32'h0);
    tick(); cyc("t1_a100", 1, 16'h0100, 0, 16'h0, 32'h0);
    tick(); cyc("t1_a101", 1, 16'h0101, 1, 16'h0100, 32'hC0DE0100);
    tick(); cyc("t1_a102", 1, 16'h0102, 1, 16'h0101, 32'hC0DE0101);
    tick(); cyc("t1_a103", 1, 16'h0103, 1, 16'h0102, 32'hC0DE0102);

    // 2: three cycles without grant at 0x104
    tick(); bus.iw_mem_gnt = 1'b0;
    cyc("t2_nogA", 1, 16'h0104, 1, 16'h0103, 32'hC0DE0103);
    tick(); cyc("t2_nogB", 1, 16'h0104, 0, 16'h0, 32'h0);
    tick(); cyc("t2_nogC", 1, 16'h0104, 0, 16'h0, 32'h0);
    tick(); bus.iw_mem_gnt = 1'b1;
    cyc("t2_gnt", 1, 16'h0104, 0, 16'h0, 32'h0);
    tick(); cyc("t2_dlv", 1, 16'h0105, 1, 16'h0104, 32'hC0DE0104);

    // 3: stall right after 0x105 is granted; it must survive in the skid
    tick(); bus.iw_stall = 1'b1;
    cyc("t3_st0", 0, 16'h0106, 0, 16'h0, 32'h0);
    tick(); cyc("t3_st1", 0, 16'h0106, 0, 16'h0, 32'h0);
    tick(); cyc("t3_st2", 0, 16'h0106, 0, 16'h0, 32'h0);
    tick(); cyc("t3_st3", 0, 16'h0106, 0, 16'h0, 32'h0);
    tick(); bus.iw_stall = 1'b0;
    cyc("t3_skid", 0, 16'h0106, 1, 16'h0105, 32'h0000DEAD);
    tick(); cyc("t3_once", 1, 16'h0106, 0, 16'h0, 32'h0);
    tick(); cyc("t3_a106", 1, 16'h0107, 1, 16'h0106, 32'hC0DE0106);

    // 4: redirect while 0x107 is in flight
    tick(); bus.iw_redirect = 1'b1; bus.iw_redirect_pc = 16'h0200;
    cyc("t4_squash", 0, 16'h0108, 0, 16'h0, 32'h0);
    tick(); bus.iw_redirect = 1'b0;
    cyc("t4_req200", 1, 16'h0200, 0, 16'h0, 32'h0);
    tick(); cyc("t4_dlv200", 1, 16'h0201, 1, 16'h0200, 32'hC0DE0200);

    // 5: redirect during a stall with the skid holding 0x201
    tick(); bus.iw_stall = 1'b1;
    cyc("t5_fill", 0, 16'h0202, 0, 16'h0, 32'h0);
    tick(); bus.iw_redirect = 1'b1; bus.iw_redirect_pc = 16'h0300;
    cyc("t5_redir", 0, 16'h0202, 0, 16'h0, 32'h0);
    tick(); bus.iw_redirect = 1'b0;
    cyc("t5_hold", 0, 16'h0300, 0, 16'h0, 32'h0);
    tick(); bus.iw_stall = 1'b0;
    cyc("t5_noskid", 0, 16'h0300, 0, 16'h0, 32'h0);
    tick(); cyc("t5_req300", 1, 16'h0300, 0, 16'h0, 32'h0);
    tick(); cyc("t5_dlv300", 1, 16'h0301, 1, 16'h0300, 32'hC0DE0300);

    // 6: wrap at the top of the address space, then reset mid-stream
    tick(); bus.iw_redirect = 1'b1; bus.iw_redirect_pc = 16'hFFFF;
    cyc("t6_redir", 0, 16'h0302, 0, 16'h0, 32'h0);
    tick(); bus.iw_redirect = 1'b0;
    cyc("t6_max", 1, 16'hFFFF, 0, 16'h0, 32'h0);
    tick(); cyc("t6_wrap", 1, 16'h0000, 1, 16'hFFFF, 32'hC0DEFFFF);
    tick(); rst = 1'b1;
    cyc("t6_prerst", 1, 16'h0001, 1, 16'h0000, 32'hC0DE0000);
    tick(); rst = 1'b0;
    cyc("t6_rst", 0, 16'h0100, 0, 16'h0, 32'h0);
    tick(); cyc("t6_restart", 1, 16'h0100, 0, 16'h0, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #20000;
    fails++;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end
endmodule
